emac_swif_loopback: RTL and testbench

EMAC_SWIF_LOOPBACK -- requirements
Module: emac_swif_loopback

---
 rtl/emac_swif_pkg.sv | 35 +++
 rtl/emac_swif_if.sv | 46 ++++
 rtl/emac_swif_frame_ram.sv | 23 ++
 rtl/emac_swif_loopback.sv | 211 +++++++++++++++++++++
 tb/tb_emac_swif_loopback.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/emac_swif_pkg.sv
// emac_swif shared types: FSM state encoding and status word layout.
// Used by the loopback top to build the TX and RX status words.
package emac_swif_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPT,
      ST_TXST,
      ST_GAPW,
      ST_RXSEND,
      ST_RXST
   } state_e;

   localparam int STATUS_W    = 18;
   localparam int BE_W        = 2;

   localparam int TXS_CNT_LSB = 0;
   localparam int TXS_CNT_W   = 10;
   localparam int TXS_BE_LSB  = 10;
   localparam int TXS_OVF_BIT = 12;

   localparam int RXS_CNT_LSB = 0;
   localparam int RXS_CNT_W   = 9;
   localparam int RXS_BE_LSB  = 9;

   // TX status count field saturates instead of wrapping
   function automatic logic [TXS_CNT_W-1:0] sat_cnt(
      input logic [31:0] c
   );
      if (c > 32'd1023)
         return 10'd1023;
      return c[TXS_CNT_W-1:0];
   endfunction

endpackage

// File: rtl/emac_swif_if.sv
// Switch interface bundle: ati_* TX side, ari_* RX side.
// master = switch side, slave = EMAC side (the loopback block).
interface emac_swif_if;

   logic        ati_val;
   logic        ati_rdy;
   logic [31:0] ati_data;
   logic [1:0]  ati_be;
   logic        ati_sof;
   logic        ati_eof;
   logic        ati_txstatus_val;
   logic [17:0] ati_txstatus;
   logic        ati_ack;

   logic        ari_val;
   logic        ari_ack;
   logic [31:0] ari_data;
   logic [1:0]  ari_be;
   logic        ari_sof;
   logic        ari_eof;
   logic        ari_rxstatus_val;
   logic        ari_frameflush;

   modport master (
      output ati_val, ati_data, ati_be,
      output ati_sof, ati_eof, ati_ack,
      output ari_ack, ari_frameflush,
      input  ati_rdy, ati_txstatus_val,
      input  ati_txstatus,
      input  ari_val, ari_data, ari_be,
      input  ari_sof, ari_eof,
      input  ari_rxstatus_val
   );

   modport slave (
      input  ati_val, ati_data, ati_be,
      input  ati_sof, ati_eof, ati_ack,
      input  ari_ack, ari_frameflush,
      output ati_rdy, ati_txstatus_val,
      output ati_txstatus,
      output ari_val, ari_data, ari_be,
      output ari_sof, ari_eof,
      output ari_rxstatus_val
   );

endinterface

// File: rtl/emac_swif_frame_ram.sv
// Frame buffer: simple dual-port RAM, one write port, registered read.
// Ports: we_i/waddr_i/wdata_i write, raddr_i -> rdata_o next cycle.
module emac_swif_frame_ram #(
   parameter int AW = 9,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [2**AW];

   always_ff @(posedge clk) begin
      if (we_i)
         mem_q[waddr_i] <= wdata_i;
      rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/emac_swif_loopback.sv
// EMAC end of the switch interface: captures one TX frame, replays it on RX.
// Ports: clk, rst (async high), sw (emac_swif_if.slave), drop_cnt.
module emac_swif_loopback
   import emac_swif_pkg::*;
#(
   parameter int ADDR_W = 9,
   parameter int GAP    = 4
) (
   input  logic       clk,
   input  logic       rst,
   emac_swif_if.slave sw,
   output logic [7:0] drop_cnt
);

   localparam int CW = ADDR_W + 1;
   localparam logic [CW-1:0] DEPTH = CW'(2**ADDR_W);
   localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

   state_e              state_q, state_d;
   logic [CW-1:0]       count_q, count_d;
   logic [ADDR_W-1:0]   rd_q, rd_d;
   logic                ovf_q, ovf_d;
   logic [BE_W-1:0]     be_q, be_d;
   logic [7:0]          gap_q, gap_d;
   logic [7:0]          drop_q;
   logic                drop_inc;
   logic                we;
   logic [ADDR_W-1:0]   waddr;
   logic [31:0]         rdata;
   logic                rdy;
   logic                tx_acc;
   logic                rx_last;
   logic [31:0]         cnt32;
   logic [STATUS_W-1:0] txs;
   logic [31:0]         rxs;

   // rdy is gated by rst so the output drops the instant reset asserts
   assign rdy     = ~rst & ((state_q == ST_IDLE) | (state_q == ST_CAPT));
   assign tx_acc  = sw.ati_val & rdy;
   assign rx_last = ({1'b0, rd_q} == count_q - CW'(1));
   assign cnt32   = 32'(count_q);
   assign drop_cnt = drop_q;

   // Read address follows rd_d so buf[rd] is already on rdata when needed
   emac_swif_frame_ram #(
      .AW (ADDR_W),
      .DW (32)
   ) u_ram (
      .clk     (clk),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (sw.ati_data),
      .raddr_i (rd_d),
      .rdata_o (rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         rd_q    <= '0;
         ovf_q   <= 1'b0;
         be_q    <= '0;
         gap_q   <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         rd_q    <= rd_d;
         ovf_q   <= ovf_d;
         be_q    <= be_d;
         gap_q   <= gap_d;
         if (drop_inc && drop_q != 8'hFF)
            drop_q <= drop_q + 8'd1;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      rd_d     = rd_q;
      ovf_d    = ovf_q;
      be_d     = be_q;
      gap_d    = gap_q;
      drop_inc = 1'b0;
      we       = 1'b0;
      waddr    = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (tx_acc) begin
               if (sw.ati_sof) begin
                  we      = 1'b1;
                  count_d = CW'(1);
                  ovf_d   = 1'b0;
                  if (sw.ati_eof) begin
                     be_d    = sw.ati_be;
                     state_d = ST_TXST;
                  end else begin
                     state_d = ST_CAPT;
                  end
               end else begin
                  drop_inc = 1'b1;
               end
            end
         end
         ST_CAPT: begin
            if (tx_acc) begin
               if (sw.ati_sof) begin
                  we       = 1'b1;
                  count_d  = CW'(1);
                  ovf_d    = 1'b0;
                  drop_inc = 1'b1;
               end else if (count_q == DEPTH) begin
                  ovf_d = 1'b1;
               end else begin
                  we      = 1'b1;
                  waddr   = count_q[ADDR_W-1:0];
                  count_d = count_q + CW'(1);
               end
               if (sw.ati_eof) begin
                  be_d    = sw.ati_be;
                  state_d = ST_TXST;
               end
            end
         end
         ST_TXST: begin
            if (sw.ati_ack) begin
               if (ovf_q) begin
                  drop_inc = 1'b1;
                  state_d  = ST_IDLE;
               end else if (GAP == 0) begin
                  rd_d    = '0;
                  state_d = ST_RXSEND;
               end else begin
                  gap_d   = '0;
                  state_d = ST_GAPW;
               end
            end
         end
         ST_GAPW: begin
            if (gap_q == GAP_LAST) begin
               rd_d    = '0;
               state_d = ST_RXSEND;
            end else begin
               gap_d = gap_q + 8'd1;
            end
         end
         ST_RXSEND: begin
            if (sw.ari_frameflush) begin
               drop_inc = 1'b1;
               state_d  = ST_IDLE;
            end else if (sw.ari_ack) begin
               if (rx_last)
                  state_d = ST_RXST;
               else
                  rd_d = rd_q + ADDR_W'(1);
            end
         end
         ST_RXST: begin
            if (sw.ari_frameflush) begin
               drop_inc = 1'b1;
               state_d  = ST_IDLE;
            end else if (sw.ari_ack) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      txs = '0;
      txs[TXS_CNT_LSB +: TXS_CNT_W] = sat_cnt(cnt32);
      txs[TXS_BE_LSB +: BE_W]       = be_q;
      txs[TXS_OVF_BIT]              = ovf_q;
      rxs = '0;
      rxs[RXS_CNT_LSB +: RXS_CNT_W] = cnt32[RXS_CNT_W-1:0];
      rxs[RXS_BE_LSB +: BE_W]       = be_q;
   end

   always_comb begin
      sw.ati_rdy          = rdy;
      sw.ati_txstatus_val = 1'b0;
      sw.ati_txstatus     = '0;
      sw.ari_val          = 1'b0;
      sw.ari_data         = '0;
      sw.ari_be           = '0;
      sw.ari_sof          = 1'b0;
      sw.ari_eof          = 1'b0;
      sw.ari_rxstatus_val = 1'b0;
      unique case (state_q)
         ST_TXST: begin
            sw.ati_txstatus_val = 1'b1;
            sw.ati_txstatus     = txs;
         end
         ST_RXSEND: begin
            sw.ari_val  = 1'b1;
            sw.ari_data = rdata;
            sw.ari_sof  = (rd_q == '0);
            sw.ari_eof  = rx_last;
            sw.ari_be   = rx_last ? be_q : '0;
         end
         ST_RXST: begin
            sw.ari_rxstatus_val = 1'b1;
            sw.ari_data         = rxs;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_emac_swif_loopback.sv
// Directed bench for emac_swif_loopback: capture, replay, drops, overflow.
// Two DUTs: default geometry (ADDR_W=9,GAP=4) and a tiny one (ADDR_W=2,GAP=0).
module tb_emac_swif_loopback;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        val = 0, ack = 0, rack = 0, flush = 0, sel = 0;
   logic        s = 0, e = 0;
   logic [31:0] d = '0;
   logic [1:0]  b = '0;
   logic [7:0]  drop_a, drop_b;

   emac_swif_if ia ();
   emac_swif_if ib ();

   assign ia.ati_data       = d;
   assign ia.ati_be         = b;
   assign ia.ati_sof        = s;
   assign ia.ati_eof        = e;
   assign ia.ati_val        = val & ~sel;
   assign ia.ati_ack        = ack & ~sel;
   assign ia.ari_ack        = rack & ~sel;
   assign ia.ari_frameflush = flush & ~sel;
   assign ib.ati_data       = d;
   assign ib.ati_be         = b;
   assign ib.ati_sof        = s;
   assign ib.ati_eof        = e;
   assign ib.ati_val        = val & sel;
   assign ib.ati_ack        = ack & sel;
   assign ib.ari_ack        = rack & sel;
   assign ib.ari_frameflush = flush & sel;

   logic        o_rdy, o_tsv, o_rv, o_rsof, o_reof, o_rsv;
   logic [17:0] o_ts;
   logic [31:0] o_rd;
   logic [1:0]  o_rbe;
   logic [7:0]  o_drop;

   assign o_rdy  = sel ? ib.ati_rdy          : ia.ati_rdy;
   assign o_tsv  = sel ? ib.ati_txstatus_val : ia.ati_txstatus_val;
   assign o_ts   = sel ? ib.ati_txstatus     : ia.ati_txstatus;
   assign o_rv   = sel ? ib.ari_val          : ia.ari_val;
   assign o_rd   = sel ? ib.ari_data         : ia.ari_data;
   assign o_rbe  = sel ? ib.ari_be           : ia.ari_be;
   assign o_rsof = sel ? ib.ari_sof          : ia.ari_sof;
   assign o_reof = sel ? ib.ari_eof          : ia.ari_eof;
   assign o_rsv  = sel ? ib.ari_rxstatus_val : ia.ari_rxstatus_val;
   assign o_drop = sel ? drop_b              : drop_a;

   emac_swif_loopback #(.ADDR_W(9), .GAP(4)) u_dut_a (
      .clk      (clk),
      .rst      (rst),
      .sw       (ia),
      .drop_cnt (drop_a)
   );

   emac_swif_loopback #(.ADDR_W(2), .GAP(0)) u_dut_b (
      .clk      (clk),
      .rst      (rst),
      .sw       (ib),
      .drop_cnt (drop_b)
   );

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_d [0:15];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tx_beat(input logic [31:0] dv, input logic sv,
                          input logic ev, input logic [1:0] bv);
      int n = 0;
      @(negedge clk);
      d = dv; s = sv; e = ev; b = bv; val = 1'b1;
      while (!o_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("tx_rdy_timeout", 32'(n), 32'd0);
      @(negedge clk);
      val = 1'b0; s = 1'b0; e = 1'b0;
   endtask

   task automatic tx_status(input string tag, input logic [17:0] exp);
      int n = 0;
      while (!o_tsv && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_tsv"}, 32'(o_tsv), 32'd1);
      check({tag, "_txst"}, 32'(o_ts), 32'(exp));
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
   endtask

   task automatic gap_wait(input string tag, input int exp);
      int n = 0;
      while (!o_rv && n < 300) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_gap"}, 32'(n), 32'(exp));
   endtask

   task automatic rx_frame(input string tag, input int n,
                           input logic [1:0] eb, input bit rnd);
      int i = 0;
      int t = 0;
      while (i < n && t < 200) begin
         rack = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (o_rv && rack) begin
            check({tag, "_data"}, o_rd, exp_d[i]);
            check({tag, "_ctl"}, 32'({o_rsof, o_reof, o_rbe}),
                  32'({i == 0, i == n - 1, (i == n - 1) ? eb : 2'b00}));
            i++;
         end
         @(negedge clk);
         t++;
      end
      rack = 1'b0;
      check({tag, "_beats"}, 32'(i), 32'(n));
      if (!rnd) check({tag, "_nobubble"}, 32'(t), 32'(n));
   endtask

   task automatic rx_stat(input string tag, input logic [31:0] exp);
      check({tag, "_rsv"}, 32'({o_rsv, o_rv}), 32'b10);
      check({tag, "_rxst"}, o_rd, exp);
      rack = 1'b1;
      @(negedge clk);
      rack = 1'b0;
      check({tag, "_idle"}, 32'({o_rsv, o_rdy}), 32'b01);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      #3;
      check("rst_rdy", 32'(o_rdy), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_outs", 32'({o_rdy, o_tsv, o_rv, o_rsv}), 32'b1000);
      check("rst_drop", 32'(o_drop), 32'd0);

      // 3-word frame, be=2
      exp_d[0] = 32'hAAAA0001; exp_d[1] = 32'hBBBB0002;
      exp_d[2] = 32'hCCCC0003;
      tx_beat(exp_d[0], 1, 0, 2'd0);
      tx_beat(exp_d[1], 0, 0, 2'd0);
      tx_beat(exp_d[2], 0, 1, 2'd2);
      tx_status("t1", 18'h00803);
      gap_wait("t1", 4);
      rx_frame("t1", 3, 2'd2, 0);
      rx_stat("t1", 32'h00000403);

      // single beat sof+eof, be=0
      exp_d[0] = 32'h12345678;
      tx_beat(exp_d[0], 1, 1, 2'd0);
      tx_status("t2", 18'h00001);
      gap_wait("t2", 4);
      rx_frame("t2", 1, 2'd0, 0);
      rx_stat("t2", 32'h00000001);

      // stray beat in IDLE, then a restart mid-frame
      tx_beat(32'hDEAD0000, 0, 0, 2'd0);
      check("t3_drop1", 32'(o_drop), 32'd1);
      exp_d[0] = 32'h50500001; exp_d[1] = 32'h50500002;
      exp_d[2] = 32'h50500003;
      tx_beat(32'h0BAD0001, 1, 0, 2'd0);
      tx_beat(32'h0BAD0002, 0, 0, 2'd0);
      tx_beat(exp_d[0], 1, 0, 2'd0);
      tx_beat(exp_d[1], 0, 0, 2'd0);
      tx_beat(exp_d[2], 0, 1, 2'd1);
      check("t3_drop2", 32'(o_drop), 32'd2);
      tx_status("t3", 18'h00403);
      gap_wait("t3", 4);
      rx_frame("t3", 3, 2'd1, 0);
      rx_stat("t3", 32'h00000203);

      // 5 words with random ari_ack
      for (int k = 0; k < 5; k++) begin
         exp_d[k] = 32'hF0000000 + 32'(k * 17);
         tx_beat(exp_d[k], k == 0, k == 4, 2'd0);
      end
      tx_status("t4", 18'h00005);
      gap_wait("t4", 4);
      rx_frame("t4", 5, 2'd0, 1);
      rx_stat("t4", 32'h00000005);

      // flush on the 2nd beat, with ari_ack also high
      exp_d[0] = 32'h11110000; exp_d[1] = 32'h22220000;
      exp_d[2] = 32'h33330000;
      tx_beat(exp_d[0], 1, 0, 2'd0);
      tx_beat(exp_d[1], 0, 0, 2'd0);
      tx_beat(exp_d[2], 0, 1, 2'd3);
      tx_status("t5", 18'h00C03);
      gap_wait("t5", 4);
      rack = 1'b1;
      check("t5_b0", o_rd, exp_d[0]);
      @(negedge clk);
      check("t5_b1", o_rd, exp_d[1]);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      rack = 1'b0;
      check("t5_flush", 32'({o_rv, o_rsv, o_rdy}), 32'b001);
      check("t5_drop", 32'(o_drop), 32'd3);

      // tiny buffer: overflow, then an exactly-full frame
      sel = 1'b1;
      for (int k = 0; k < 6; k++)
         tx_beat(32'h77770000 + 32'(k), k == 0, k == 5, 2'd3);
      tx_status("t6", 18'h01C04);
      acc = 0;
      repeat (6) begin
         acc += int'(o_rv) + int'(o_rsv);
         @(negedge clk);
      end
      check("t6_norx", 32'(acc), 32'd0);
      check("t6_drop", 32'(o_drop), 32'd1);
      for (int k = 0; k < 4; k++) begin
         exp_d[k] = 32'h99990000 + 32'(k);
         tx_beat(exp_d[k], k == 0, k == 3, 2'd1);
      end
      tx_status("t7", 18'h00404);
      gap_wait("t7", 0);
      rx_frame("t7", 4, 2'd1, 0);
      rx_stat("t7", 32'h00000204);

      // reset in the middle of a capture
      sel = 1'b0;
      tx_beat(32'hABCD0001, 1, 0, 2'd0);
      tx_beat(32'hABCD0002, 0, 0, 2'd0);
      rst = 1'b1;
      #1;
      check("t8_outs", 32'({o_rdy, o_tsv, o_rv, o_rsv}), 32'd0);
      check("t8_drop", 32'(o_drop), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("t8_rdy", 32'(o_rdy), 32'd1);
      tx_beat(32'hABCD0003, 0, 1, 2'd0);
      acc = 0;
      repeat (5) begin
         acc += int'(o_tsv);
         @(negedge clk);
      end
      check("t8_nots", 32'(acc), 32'd0);
      check("t8_drop1", 32'(o_drop), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
